// File: rtl/nn_mgr_pkg.sv
// rtl/nn_mgr_pkg.sv - shared reader states, default address map and status-word layout
package nn_mgr_pkg;

   typedef enum logic [1:0] {
      IDLE_ST  = 2'd0,
      ARMED_ST = 2'd1,
      AVAIL_ST = 2'd2
   } rd_state_t;

   localparam int DEF_WIDTH      = 32;
   localparam int DEF_LENGHT_I   = 32;
   localparam int DEF_LENGHT_MID = 8;
   localparam int DEF_LENGHT_O   = 2;

   // Outputs sit right after the weight, bias and input regions of the manager's map.
   localparam int OUT_BASE    = DEF_LENGHT_I*DEF_LENGHT_MID + DEF_LENGHT_MID*DEF_LENGHT_O
                                + DEF_LENGHT_I + 1;
   localparam int STATUS_ADDR = OUT_BASE + DEF_LENGHT_O;

   localparam int ST_READY_BIT = 0;
   localparam int ST_DOWN_BIT  = 1;
   localparam int ST_STATE_LSB = 2;
   localparam int ST_MASK_LSB  = 4;

   function automatic int st_ovr_bit(input int n_out);
      return ST_MASK_LSB + n_out;
   endfunction

endpackage

// File: rtl/nn_argmax.sv
// rtl/nn_argmax.sv - index of the largest signed word; ties resolve to the lowest index
module nn_argmax #(
   parameter int WIDTH = 32,
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0][WIDTH-1:0] data,
   output logic [IDX_W-1:0]        idx
);

   logic signed [WIDTH-1:0] best;

   always_comb begin
      best = $signed(data[0]);
      idx  = '0;
      // Strict compare keeps the earliest index on equal values.
      for (int i = 1; i < N; i++) begin
         if ($signed(data[i]) > best) begin
            best = $signed(data[i]);
            idx  = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/nn_result_reader.sv
// rtl/nn_result_reader.sv - captures network outputs and serves them on the CPU bus
// Optional argmax status field: NN_RESULT_ARGMAX_EN.
module nn_result_reader #(
   parameter int WIDTH       = nn_mgr_pkg::DEF_WIDTH,
   parameter int LENGHT_I    = nn_mgr_pkg::DEF_LENGHT_I,
   parameter int LENGHT_MID  = nn_mgr_pkg::DEF_LENGHT_MID,
   parameter int LENGHT_O    = nn_mgr_pkg::DEF_LENGHT_O,
   parameter int OUT_BASE    = LENGHT_I*LENGHT_MID + LENGHT_MID*LENGHT_O + LENGHT_I + 1,
   parameter int STATUS_ADDR = OUT_BASE + LENGHT_O,
   parameter int WIDTH_ADDR  = $clog2(STATUS_ADDR + 1)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             arm,
   input  logic                             nw_valid,
   input  logic [LENGHT_O-1:0][WIDTH-1:0]   nw_data,
   input  logic                             read,
   input  logic                             write,
   input  logic [WIDTH_ADDR-1:0]            address,
   output logic [WIDTH-1:0]                 out_d,
   output logic                             rd_valid,
   output logic                             ready,
   output logic                             down,
   output logic                             consumed
);

   import nn_mgr_pkg::*;

   localparam int ST_OVR = st_ovr_bit(LENGHT_O);
   localparam int IDX_W  = (LENGHT_O > 1) ? $clog2(LENGHT_O) : 1;

   rd_state_t                      state, state_d;
   logic [LENGHT_O-1:0][WIDTH-1:0] result;
   logic [LENGHT_O-1:0]            rd_mask, mask_d, hit;
   logic                           overrun, ovr_d, capture, consumed_d;
   logic                           qrd, stat_hit, rd_valid_d;
   logic [WIDTH-1:0]               status, out_d_d;

`ifdef NN_RESULT_ARGMAX_EN
   logic [IDX_W-1:0] amax_idx_c, amax_idx;
   logic             amax_vld;

   nn_argmax #(.WIDTH(WIDTH), .N(LENGHT_O), .IDX_W(IDX_W)) u_argmax (
      .data (nw_data),
      .idx  (amax_idx_c)
   );
`endif

   assign ready = (state == IDLE_ST);
   assign down  = (state == AVAIL_ST);
   assign qrd   = read && !write;

   always_comb begin
      status                     = '0;
      status[ST_READY_BIT]       = ready;
      status[ST_DOWN_BIT]        = down;
      status[ST_STATE_LSB +: 2]  = state;
      status[ST_MASK_LSB +: LENGHT_O] = rd_mask;
      status[ST_OVR]             = overrun;
`ifdef NN_RESULT_ARGMAX_EN
      status[WIDTH-1 -: IDX_W+1] = {amax_vld, amax_idx};
`endif
   end

   always_comb begin
      hit = '0;
      for (int i = 0; i < LENGHT_O; i++)
         hit[i] = qrd && (address == WIDTH_ADDR'(OUT_BASE + i));
      stat_hit = qrd && (address == WIDTH_ADDR'(STATUS_ADDR));

      state_d    = state;
      mask_d     = rd_mask;
      ovr_d      = overrun;
      capture    = 1'b0;
      consumed_d = 1'b0;
      case (state)
         IDLE_ST:  ;
         ARMED_ST: if (nw_valid) begin
            capture = 1'b1;
            state_d = AVAIL_ST;
         end
         AVAIL_ST: begin
            mask_d = rd_mask | hit;
            if (nw_valid) ovr_d = 1'b1;
            if (&mask_d) begin
               state_d    = IDLE_ST;
               consumed_d = 1'b1;
            end
         end
         default: state_d = IDLE_ST;
      endcase
      // Arm overrides everything, including a coincident capture or completion.
      if (arm) begin
         state_d    = ARMED_ST;
         mask_d     = '0;
         ovr_d      = 1'b0;
         capture    = 1'b0;
         consumed_d = 1'b0;
      end

      rd_valid_d = (|hit) || stat_hit;
      out_d_d    = '0;
      if (state == AVAIL_ST)
         for (int i = 0; i < LENGHT_O; i++)
            if (hit[i]) out_d_d = result[i];
      if (stat_hit) out_d_d = status;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE_ST;
         result   <= '0;
         rd_mask  <= '0;
         overrun  <= 1'b0;
         out_d    <= '0;
         rd_valid <= 1'b0;
         consumed <= 1'b0;
      end else begin
         state    <= state_d;
         rd_mask  <= mask_d;
         overrun  <= ovr_d;
         out_d    <= out_d_d;
         rd_valid <= rd_valid_d;
         consumed <= consumed_d;
         if (capture) result <= nw_data;
      end
   end

`ifdef NN_RESULT_ARGMAX_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         amax_idx <= '0;
         amax_vld <= 1'b0;
      end else if (arm) begin
         amax_vld <= 1'b0;
      end else if (capture) begin
         amax_idx <= amax_idx_c;
         amax_vld <= 1'b1;
      end
   end
`endif

endmodule
